branch_exec_unit: RTL and testbench
===================================

BRANCH_EXEC_UNIT -- requirements
Module: branch_exec_unit

Interface
REQ-001 SHALL have parameters: WIDTH, default 31, data/address MSB index; ROB, default 2, ROB tag MSB; C_WIDTH, default 7, control MSB.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state on rising edge
- globalReset  in  1  synchronous, active-high reset
- clear  in  1  flush request
- validCommit  in  1  qualifies clear
- issueValid  in  1  RS entry selected with execute
- ready  out  1  unit can accept an issue this cycle
- instrRob  in  ROB+1  ROB tag of the issued branch
- instrInfo  in  C_WIDTH+1  control: [2:0] funct3, [3] JAL, [4] JALR, [5] conditional, [7:6] reserved
- src1, src2  in  WIDTH+1 signed  operands
- predictedAddress  in  WIDTH+1  predicted next PC
- targetAddress  in  WIDTH+1  branch target (conditional/JAL); sign-extended immediate (JALR)
- branchResult  in  WIDTH+1  sequential PC (PC+4)
- cdbGrant  in  1  CDB arbiter grant
- cdbReq  out  1  CDB request
- validBroadcast  out  1  result on CDB this cycle
- robEntry  out  ROB+1  tag broadcast
- result  out  WIDTH+1  link value broadcast
- mispredict  out  1  misprediction, qualified by validBroadcast
- correctPC  out  WIDTH+1  resolved next PC
- taken  out  1  resolved direction
- branchCount, mispredictCount  out  16 each  statistics

Function
REQ-003 Two registered stages SHALL be used: R (operand capture) and W (resolved result awaiting CDB).
REQ-004 An issue SHALL be accepted at an edge iff issueValid & ready; accepted data loads R.
REQ-005 ready SHALL equal !R.valid | (W advances this cycle), where W advances when !W.valid or (cdbReq & cdbGrant).
REQ-006 R SHALL move into W at an edge when R.valid and W advances; R SHALL then clear unless a new issue is accepted in the same cycle.
REQ-007 Resolution SHALL be combinational from R and registered into W:
- conditional: funct3 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; 010/011 not taken
- JAL: taken=1, correctPC=targetAddress
- JALR: taken=1, correctPC=(src1+targetAddress) with bit0 forced 0, 32-bit wrap
- conditional: correctPC = taken ? targetAddress : branchResult
- mispredict = (correctPC != predictedAddress)
- result = branchResult for JAL/JALR, 0 for conditional
REQ-008 If none of bits [3],[4],[5] is set, the unit SHALL resolve as not taken, correctPC=branchResult, result 0.
REQ-009 cdbReq SHALL equal W.valid; validBroadcast SHALL equal cdbReq & cdbGrant, combinational.
REQ-010 robEntry, result, correctPC, taken, mispredict SHALL be driven from W; mispredict SHALL be 0 when !validBroadcast.
REQ-011 W SHALL hold stable while cdbReq & !cdbGrant.
REQ-012 Minimum latency: issue accepted at the end of cycle N SHALL give cdbReq high in cycle N+2; with continuous grant, throughput SHALL be one branch per cycle.
REQ-013 clear & validCommit SHALL invalidate R and W at the next edge; an issue presented in that cycle SHALL be discarded; validBroadcast is unaffected in that same cycle.
REQ-014 branchCount SHALL increment on each validBroadcast; mispredictCount SHALL increment on validBroadcast & mispredict; both SHALL saturate at 16'hFFFF.

Reset
REQ-015 On globalReset at an edge, R.valid, W.valid, cdbReq, validBroadcast, mispredict and taken SHALL be 0; robEntry, result, correctPC and both counters SHALL be 0; ready SHALL be 1 in the following cycle.
REQ-016 globalReset SHALL take priority over issue, flush and grant in the same cycle.

Verification
REQ-017 BEQ, src1=src2=5, targetAddress=0x100, predictedAddress=0x100, grant held -> cdbReq at N+2, taken=1, correctPC=0x100, mispredict=0, result=0.
REQ-018 BLTU, src1=0xFFFFFFFF, src2=1, branchResult=0x44, predictedAddress=0x80 -> taken=0, correctPC=0x44, mispredict=1, mispredictCount=1.
REQ-019 JALR, src1=0x1001, targetAddress=0x4, branchResult=0x20 -> correctPC=0x1004, result=0x20, taken=1.
REQ-020 Grant withheld 3 cycles with R and W full -> ready=0, W outputs stable; grant on 4th cycle -> broadcast, ready=1 in the same cycle.
REQ-021 clear & validCommit with R and W valid plus a concurrent issue -> next cycle cdbReq=0, ready=1, no broadcast of any of the three.
REQ-022 globalReset asserted while cdbReq=1 and counters are nonzero -> next cycle all outputs 0 and ready=1.

Source files
------------

// File: rtl/branch_exec_unit.sv
// Branch execution unit: captures an issued branch (R), resolves direction and
// next PC, and holds the resolved result (W) until the CDB grants a broadcast.
module branch_exec_unit #(
  parameter int WIDTH   = 31,
  parameter int ROB     = 2,
  parameter int C_WIDTH = 7
) (
  input  logic                clk,
  input  logic                globalReset,
  input  logic                clear,
  input  logic                validCommit,
  input  logic                issueValid,
  output logic                ready,
  input  logic [ROB:0]        instrRob,
  input  logic [C_WIDTH:0]    instrInfo,
  input  logic signed [WIDTH:0] src1,
  input  logic signed [WIDTH:0] src2,
  input  logic [WIDTH:0]      predictedAddress,
  input  logic [WIDTH:0]      targetAddress,
  input  logic [WIDTH:0]      branchResult,
  input  logic                cdbGrant,
  output logic                cdbReq,
  output logic                validBroadcast,
  output logic [ROB:0]        robEntry,
  output logic [WIDTH:0]      result,
  output logic                mispredict,
  output logic [WIDTH:0]      correctPC,
  output logic                taken,
  output logic [15:0]         branchCount,
  output logic [15:0]         mispredictCount
);

  logic                 r_rValid;
  logic [ROB:0]         r_rRob;
  logic [C_WIDTH:0]     r_rInfo;
  logic signed [WIDTH:0] r_rSrc1;
  logic signed [WIDTH:0] r_rSrc2;
  logic [WIDTH:0]       r_rPred;
  logic [WIDTH:0]       r_rTarget;
  logic [WIDTH:0]       r_rSeq;

  logic                 r_wValid;
  logic [ROB:0]         r_wRob;
  logic [WIDTH:0]       r_wResult;
  logic [WIDTH:0]       r_wCorrectPC;
  logic                 r_wTaken;
  logic                 r_wMispredict;

  logic [15:0]          r_branchCount;
  logic [15:0]          r_mispredictCount;

  logic                 w_wAdvance;
  logic                 w_accept;
  logic                 w_flush;
  logic                 w_cond;
  logic                 w_taken;
  logic [WIDTH:0]       w_correctPC;
  logic [WIDTH:0]       w_result;
  logic                 w_mispredict;
  logic [WIDTH:0]       w_jalrSum;
  logic                 w_unused;

  assign w_wAdvance = !r_wValid || (cdbReq && cdbGrant);
  assign ready      = !r_rValid || w_wAdvance;
  assign w_accept   = issueValid && ready;
  assign w_flush    = clear && validCommit;
  assign w_jalrSum  = r_rSrc1 + r_rTarget;
  assign w_unused   = ^r_rInfo[C_WIDTH:6];

  always_comb begin
    w_cond = 1'b0;
    case (r_rInfo[2:0])
      3'b000:  w_cond = (r_rSrc1 == r_rSrc2);
      3'b001:  w_cond = (r_rSrc1 != r_rSrc2);
      3'b100:  w_cond = (r_rSrc1 < r_rSrc2);
      3'b101:  w_cond = (r_rSrc1 >= r_rSrc2);
      3'b110:  w_cond = ($unsigned(r_rSrc1) < $unsigned(r_rSrc2));
      3'b111:  w_cond = ($unsigned(r_rSrc1) >= $unsigned(r_rSrc2));
      default: w_cond = 1'b0;
    endcase
  end

  // JALR wins over JAL over conditional if several kind bits are set at once.
  always_comb begin
    w_taken     = 1'b0;
    w_correctPC = r_rSeq;
    w_result    = '0;
    if (r_rInfo[4]) begin
      w_taken     = 1'b1;
      w_correctPC = {w_jalrSum[WIDTH:1], 1'b0};
      w_result    = r_rSeq;
    end else if (r_rInfo[3]) begin
      w_taken     = 1'b1;
      w_correctPC = r_rTarget;
      w_result    = r_rSeq;
    end else if (r_rInfo[5]) begin
      w_taken     = w_cond;
      w_correctPC = w_cond ? r_rTarget : r_rSeq;
    end
  end

  assign w_mispredict = (w_correctPC != r_rPred);

  always_ff @(posedge clk) begin
    if (globalReset) begin
      r_rValid      <= 1'b0;
      r_rRob        <= '0;
      r_rInfo       <= '0;
      r_rSrc1       <= '0;
      r_rSrc2       <= '0;
      r_rPred       <= '0;
      r_rTarget     <= '0;
      r_rSeq        <= '0;
      r_wValid      <= 1'b0;
      r_wRob        <= '0;
      r_wResult     <= '0;
      r_wCorrectPC  <= '0;
      r_wTaken      <= 1'b0;
      r_wMispredict <= 1'b0;
    end else if (w_flush) begin
      r_rValid <= 1'b0;
      r_wValid <= 1'b0;
    end else begin
      if (w_wAdvance) begin
        r_wValid <= r_rValid;
        if (r_rValid) begin
          r_wRob        <= r_rRob;
          r_wResult     <= w_result;
          r_wCorrectPC  <= w_correctPC;
          r_wTaken      <= w_taken;
          r_wMispredict <= w_mispredict;
        end
      end
      if (w_accept) begin
        r_rValid  <= 1'b1;
        r_rRob    <= instrRob;
        r_rInfo   <= instrInfo;
        r_rSrc1   <= src1;
        r_rSrc2   <= src2;
        r_rPred   <= predictedAddress;
        r_rTarget <= targetAddress;
        r_rSeq    <= branchResult;
      end else if (r_rValid && w_wAdvance) begin
        r_rValid <= 1'b0;
      end
    end
  end

  // Statistics count broadcasts even in a flush cycle; they saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (globalReset) begin
      r_branchCount     <= '0;
      r_mispredictCount <= '0;
    end else if (validBroadcast) begin
      if (r_branchCount != 16'hFFFF) r_branchCount <= r_branchCount + 16'd1;
      if (mispredict && r_mispredictCount != 16'hFFFF)
        r_mispredictCount <= r_mispredictCount + 16'd1;
    end
  end

  assign cdbReq          = r_wValid;
  assign validBroadcast  = cdbReq && cdbGrant;
  assign robEntry        = r_wRob;
  assign result          = r_wResult;
  assign correctPC       = r_wCorrectPC;
  assign taken           = r_wTaken;
  assign mispredict      = r_wMispredict && validBroadcast;
  assign branchCount     = r_branchCount;
  assign mispredictCount = r_mispredictCount;

endmodule

// File: tb/tb_branch_exec_unit.sv
// Directed bench for branch_exec_unit: latency, resolution kinds, CDB stall,
// flush and reset priority, each checked against hand-computed values.
module tb_branch_exec_unit;

  logic        clk = 1'b0;
  logic        globalReset;
  logic        clear;
  logic        validCommit;
  logic        issueValid;
  logic        ready;
  logic [2:0]  instrRob;
  logic [7:0]  instrInfo;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] predictedAddress;
  logic [31:0] targetAddress;
  logic [31:0] branchResult;
  logic        cdbGrant;
  logic        cdbReq;
  logic        validBroadcast;
  logic [2:0]  robEntry;
  logic [31:0] result;
  logic        mispredict;
  logic [31:0] correctPC;
  logic        taken;
  logic [15:0] branchCount;
  logic [15:0] mispredictCount;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  always #5 clk = ~clk;

  branch_exec_unit dut (
    .clk(clk), .globalReset(globalReset), .clear(clear), .validCommit(validCommit),
    .issueValid(issueValid), .ready(ready), .instrRob(instrRob), .instrInfo(instrInfo),
    .src1(src1), .src2(src2), .predictedAddress(predictedAddress),
    .targetAddress(targetAddress), .branchResult(branchResult), .cdbGrant(cdbGrant),
    .cdbReq(cdbReq), .validBroadcast(validBroadcast), .robEntry(robEntry),
    .result(result), .mispredict(mispredict), .correctPC(correctPC), .taken(taken),
    .branchCount(branchCount), .mispredictCount(mispredictCount)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] rob, input logic [7:0] info,
                               input logic [31:0] s1, input logic [31:0] s2,
                               input logic [31:0] pred, input logic [31:0] tgt,
                               input logic [31:0] seq);
    issueValid       = 1'b1;
    instrRob         = rob;
    instrInfo        = info;
    src1             = s1;
    src2             = s2;
    predictedAddress = pred;
    targetAddress    = tgt;
    branchResult     = seq;
  endtask

  // Issue one branch with grant held and check its broadcast two cycles later.
  task automatic issueAndCheck(input string tag, input logic [2:0] rob,
                               input logic [7:0] info, input logic [31:0] s1,
                               input logic [31:0] s2, input logic [31:0] pred,
                               input logic [31:0] tgt, input logic [31:0] seq,
                               input logic expTaken, input logic [31:0] expPC,
                               input logic [31:0] expResult, input logic expMis);
    applyStimulus(rob, info, s1, s2, pred, tgt, seq);
    tick();
    issueValid = 1'b0;
    #1;
    checkOutput({tag, "_lat1"}, {31'd0, cdbReq}, 32'd0);
    tick();
    checkOutput({tag, "_vb"}, {31'd0, validBroadcast}, 32'd1);
    checkOutput({tag, "_rob"}, {29'd0, robEntry}, {29'd0, rob});
    checkOutput({tag, "_taken"}, {31'd0, taken}, {31'd0, expTaken});
    checkOutput({tag, "_pc"}, correctPC, expPC);
    checkOutput({tag, "_result"}, result, expResult);
    checkOutput({tag, "_mis"}, {31'd0, mispredict}, {31'd0, expMis});
    tick();
  endtask

  initial begin
    globalReset = 1'b1;
    clear = 1'b0;
    validCommit = 1'b0;
    issueValid = 1'b0;
    instrRob = '0;
    instrInfo = '0;
    src1 = '0;
    src2 = '0;
    predictedAddress = '0;
    targetAddress = '0;
    branchResult = '0;
    cdbGrant = 1'b0;
    tick();
    tick();
    globalReset = 1'b0;
    #1;
    checkOutput("rst_ready", {31'd0, ready}, 32'd1);
    checkOutput("rst_cdbReq", {31'd0, cdbReq}, 32'd0);
    checkOutput("rst_pc", correctPC, 32'd0);
    checkOutput("rst_bcount", {16'd0, branchCount}, 32'd0);

    // BEQ taken, correctly predicted: minimum latency with grant held
    cdbGrant = 1'b1;
    applyStimulus(3'd1, 8'h20, 32'd5, 32'd5, 32'h100, 32'h100, 32'h44);
    #1;
    checkOutput("beq_ready", {31'd0, ready}, 32'd1);
    tick();
    issueValid = 1'b0;
    #1;
    checkOutput("beq_n1_req", {31'd0, cdbReq}, 32'd0);
    tick();
    checkOutput("beq_n2_req", {31'd0, cdbReq}, 32'd1);
    checkOutput("beq_vb", {31'd0, validBroadcast}, 32'd1);
    checkOutput("beq_taken", {31'd0, taken}, 32'd1);
    checkOutput("beq_pc", correctPC, 32'h100);
    checkOutput("beq_mis", {31'd0, mispredict}, 32'd0);
    checkOutput("beq_result", result, 32'd0);
    checkOutput("beq_rob", {29'd0, robEntry}, 32'd1);
    tick();
    checkOutput("beq_bcount", {16'd0, branchCount}, 32'd1);
    checkOutput("beq_idle", {31'd0, cdbReq}, 32'd0);

    // BLTU then JALR back to back: one-per-cycle throughput
    applyStimulus(3'd2, 8'h26, 32'hFFFF_FFFF, 32'd1, 32'h80, 32'h80, 32'h44);
    tick();
    applyStimulus(3'd3, 8'h10, 32'h1001, 32'd0, 32'h1004, 32'h4, 32'h20);
    #1;
    checkOutput("jalr_ready", {31'd0, ready}, 32'd1);
    tick();
    issueValid = 1'b0;
    #1;
    checkOutput("bltu_vb", {31'd0, validBroadcast}, 32'd1);
    checkOutput("bltu_rob", {29'd0, robEntry}, 32'd2);
    checkOutput("bltu_taken", {31'd0, taken}, 32'd0);
    checkOutput("bltu_pc", correctPC, 32'h44);
    checkOutput("bltu_mis", {31'd0, mispredict}, 32'd1);
    tick();
    checkOutput("jalr_rob", {29'd0, robEntry}, 32'd3);
    checkOutput("jalr_pc", correctPC, 32'h1004);
    checkOutput("jalr_result", result, 32'h20);
    checkOutput("jalr_taken", {31'd0, taken}, 32'd1);
    checkOutput("jalr_mis", {31'd0, mispredict}, 32'd0);
    checkOutput("bltu_mcount", {16'd0, mispredictCount}, 32'd1);
    checkOutput("bltu_bcount", {16'd0, branchCount}, 32'd2);
    tick();
    checkOutput("jalr_bcount", {16'd0, branchCount}, 32'd3);

    issueAndCheck("blt", 3'd1, 8'h24, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h200, 32'h50,
                  1'b1, 32'h200, 32'd0, 1'b0);
    issueAndCheck("bge", 3'd4, 8'h25, 32'hFFFF_FFFF, 32'd1, 32'h54, 32'h250, 32'h54,
                  1'b0, 32'h54, 32'd0, 1'b0);
    issueAndCheck("jal", 3'd2, 8'h08, 32'd0, 32'd0, 32'h64, 32'h300, 32'h60,
                  1'b1, 32'h300, 32'h60, 1'b1);
    issueAndCheck("nokind", 3'd3, 8'h00, 32'd7, 32'd7, 32'h70, 32'h900, 32'h70,
                  1'b0, 32'h70, 32'd0, 1'b0);
    issueAndCheck("f3rsvd", 3'd5, 8'h22, 32'd3, 32'd3, 32'h74, 32'h500, 32'h74,
                  1'b0, 32'h74, 32'd0, 1'b0);
    checkOutput("mix_bcount", {16'd0, branchCount}, 32'd8);
    checkOutput("mix_mcount", {16'd0, mispredictCount}, 32'd2);

    // Grant withheld three cycles with R and W both full
    cdbGrant = 1'b0;
    applyStimulus(3'd4, 8'h20, 32'd9, 32'd9, 32'h400, 32'h400, 32'h404);
    tick();
    applyStimulus(3'd5, 8'h21, 32'd1, 32'd2, 32'h500, 32'h500, 32'h504);
    tick();
    issueValid = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_ready", {31'd0, ready}, 32'd0);
      checkOutput("stall_vb", {31'd0, validBroadcast}, 32'd0);
      checkOutput("stall_rob", {29'd0, robEntry}, 32'd4);
      checkOutput("stall_pc", correctPC, 32'h400);
      tick();
    end
    cdbGrant = 1'b1;
    #1;
    checkOutput("grant_vb", {31'd0, validBroadcast}, 32'd1);
    checkOutput("grant_ready", {31'd0, ready}, 32'd1);
    checkOutput("grant_rob", {29'd0, robEntry}, 32'd4);
    tick();
    checkOutput("bne_rob", {29'd0, robEntry}, 32'd5);
    checkOutput("bne_pc", correctPC, 32'h500);
    tick();
    checkOutput("stall_bcount", {16'd0, branchCount}, 32'd10);

    // Flush with R and W valid plus a concurrent issue
    cdbGrant = 1'b0;
    applyStimulus(3'd6, 8'h20, 32'd1, 32'd1, 32'h600, 32'h600, 32'h604);
    tick();
    applyStimulus(3'd7, 8'h20, 32'd1, 32'd1, 32'h700, 32'h700, 32'h704);
    tick();
    applyStimulus(3'd1, 8'h08, 32'd0, 32'd0, 32'h0, 32'h800, 32'h804);
    clear = 1'b1;
    validCommit = 1'b1;
    #1;
    checkOutput("flush_pre_req", {31'd0, cdbReq}, 32'd1);
    tick();
    clear = 1'b0;
    validCommit = 1'b0;
    issueValid = 1'b0;
    #1;
    checkOutput("flush_req", {31'd0, cdbReq}, 32'd0);
    checkOutput("flush_ready", {31'd0, ready}, 32'd1);
    cdbGrant = 1'b1;
    tick();
    checkOutput("flush_req2", {31'd0, cdbReq}, 32'd0);
    tick();
    checkOutput("flush_req3", {31'd0, cdbReq}, 32'd0);
    checkOutput("flush_bcount", {16'd0, branchCount}, 32'd10);

    // Reset while a broadcast is pending and counters are nonzero
    cdbGrant = 1'b0;
    applyStimulus(3'd2, 8'h08, 32'd0, 32'd0, 32'h0, 32'h900, 32'h904);
    tick();
    issueValid = 1'b0;
    tick();
    checkOutput("prerst_req", {31'd0, cdbReq}, 32'd1);
    globalReset = 1'b1;
    cdbGrant = 1'b1;
    applyStimulus(3'd3, 8'h08, 32'd0, 32'd0, 32'h0, 32'hA00, 32'hA04);
    tick();
    globalReset = 1'b0;
    issueValid = 1'b0;
    #1;
    checkOutput("rst2_req", {31'd0, cdbReq}, 32'd0);
    checkOutput("rst2_vb", {31'd0, validBroadcast}, 32'd0);
    checkOutput("rst2_ready", {31'd0, ready}, 32'd1);
    checkOutput("rst2_rob", {29'd0, robEntry}, 32'd0);
    checkOutput("rst2_result", result, 32'd0);
    checkOutput("rst2_pc", correctPC, 32'd0);
    checkOutput("rst2_taken", {31'd0, taken}, 32'd0);
    checkOutput("rst2_mis", {31'd0, mispredict}, 32'd0);
    checkOutput("rst2_bcount", {16'd0, branchCount}, 32'd0);
    checkOutput("rst2_mcount", {16'd0, mispredictCount}, 32'd0);
    tick();
    checkOutput("rst2_req_next", {31'd0, cdbReq}, 32'd0);
    tick();
    checkOutput("rst2_req_late", {31'd0, cdbReq}, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
